// File: rtl/priority_4_decoder.sv
// priority_4_decoder: packs a frame of 2-bit codes into one-hot nibble slots and holds it until the consumer takes it
module priority_4_decoder #(
  parameter int FRAME = 4,
  parameter int CW = $clog2(FRAME) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_code,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4*FRAME-1:0] out_data,
  output logic [CW-1:0]      out_len,
  output logic               out_short
);
  typedef enum logic {COLLECT, HOLD} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_count;
  logic [4*FRAME-1:0] r_slots;
  logic w_accept, w_close, w_release;
  assign w_accept = in_valid && r_state == COLLECT;
  assign w_close = w_accept && (in_last || r_count == CW'(FRAME - 1));
  assign w_release = r_state == HOLD && out_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= COLLECT;
    else r_state <= w_next;
  always_comb
    w_next = r_state == COLLECT ? (w_close ? HOLD : COLLECT) : (out_ready ? COLLECT : HOLD);
  always_comb begin
    in_ready = r_state == COLLECT;
    out_valid = r_state == HOLD;
    out_data = r_slots;
    out_len = r_count;
    out_short = r_state == HOLD && r_count < CW'(FRAME);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_count <= '0;
      r_slots <= '0;
    end else if (w_release) begin
      r_count <= '0;
      r_slots <= '0;
    end else if (w_accept) begin
      r_count <= r_count + 1'b1;
      for (int k = 0; k < FRAME; k++)
        if (r_count == CW'(k)) r_slots[4*k +: 4] <= 4'b0001 << in_code;
    end
endmodule
